// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared fetch-stage types and constants.
package if_fetch_unit_pkg;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {FETCH, HELD, SQUASH} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    function automatic if_id_t bubble_of(input logic [31:0] nop);
        return '{valid: 1'b0, instr: nop, pc4: 32'd0};
    endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: PC, instruction-memory, hazard and IF/ID signals of the fetch stage.
interface if_fetch_unit_if;
    logic [31:0] Pc;
    logic [31:0] Next_Pc;
    logic        Pc_Load;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Data;
    logic        Hold;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic        IfId_Valid;
    logic [31:0] IfId_Instr;
    logic [31:0] IfId_Pc4;

    modport master (
        input  Pc, Imem_Ack, Imem_Data, Hold, Redirect, Redirect_Target,
        output Next_Pc, Pc_Load, Imem_Req, Imem_Addr, IfId_Valid, IfId_Instr, IfId_Pc4
    );

    modport slave (
        output Pc, Imem_Ack, Imem_Data, Hold, Redirect, Redirect_Target,
        input  Next_Pc, Pc_Load, Imem_Req, Imem_Addr, IfId_Valid, IfId_Instr, IfId_Pc4
    );
endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble beats load, otherwise holds.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic   Clk,
    input  logic   Rst,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);
    always_ff @(posedge Clk) begin
        if (Rst || bubble)
            q <= bubble_of(NOP);
        else if (load)
            q <= d;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch control FSM, PC steering, imem handshake and IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] PC_INC    = if_fetch_unit_pkg::PC_INC,
    parameter logic [31:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
    input logic           Clk,
    input logic           Rst,
    if_fetch_unit_if.master bus
);
    import if_fetch_unit_pkg::*;

    state_t      state, state_n;
    logic [31:0] pc4, sq_addr, buf_instr, buf_pc4;
    logic        ld, bub, buf_ld, sq_ld;
    if_id_t      d, q;

    assign pc4 = bus.Pc + PC_INC;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= FETCH;
            buf_instr <= 32'd0;
            buf_pc4   <= 32'd0;
            sq_addr   <= 32'd0;
        end else begin
            state <= state_n;
            if (buf_ld) begin
                buf_instr <= bus.Imem_Data;
                buf_pc4   <= pc4;
            end
            if (sq_ld)
                sq_addr <= bus.Pc;
        end
    end

    always_comb begin
        state_n       = state;
        ld            = 1'b0;
        bub           = 1'b0;
        buf_ld        = 1'b0;
        sq_ld         = 1'b0;
        d             = '{valid: 1'b1, instr: bus.Imem_Data, pc4: pc4};
        bus.Imem_Req  = !Rst && state != HELD;
        bus.Imem_Addr = state == SQUASH ? sq_addr : bus.Pc;
        bus.Pc_Load   = 1'b0;
        bus.Next_Pc   = pc4;
        if (bus.Redirect) begin
            bus.Pc_Load = 1'b1;
            bus.Next_Pc = bus.Redirect_Target;
            bub         = 1'b1;
            // an unacknowledged request must still be drained before refetching
            state_n     = (state != HELD && !bus.Imem_Ack) ? SQUASH : FETCH;
            sq_ld       = state == FETCH && !bus.Imem_Ack;
        end else begin
            case (state)
                FETCH: begin
                    bus.Pc_Load = bus.Imem_Ack;
                    ld          = bus.Imem_Ack && !bus.Hold;
                    buf_ld      = bus.Imem_Ack && bus.Hold;
                    bub         = !bus.Imem_Ack && !bus.Hold;
                    state_n     = (bus.Imem_Ack && bus.Hold) ? HELD : FETCH;
                end
                HELD: begin
                    ld      = !bus.Hold;
                    d       = '{valid: 1'b1, instr: buf_instr, pc4: buf_pc4};
                    state_n = bus.Hold ? HELD : FETCH;
                end
                default: begin
                    bub     = !bus.Hold;
                    state_n = bus.Imem_Ack ? FETCH : SQUASH;
                end
            endcase
        end
        if (Rst)
            bus.Pc_Load = 1'b0;
    end

    if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .Clk    (Clk),
        .Rst    (Rst),
        .load   (ld),
        .bubble (bub),
        .d      (d),
        .q      (q)
    );

    assign bus.IfId_Valid = q.valid;
    assign bus.IfId_Instr = q.instr;
    assign bus.IfId_Pc4   = q.pc4;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycles with queued expectations checked by a negedge monitor.
module tb_if_fetch_unit;
    typedef struct {
        int          id;
        logic        req;
        logic [31:0] addr;
        logic        ld;
        logic [31:0] npc;
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;

    logic        Clk, Rst, pc_set;
    logic [31:0] pc_val;
    int          checks, errors, sid;
    exp_t        q[$];

    if_fetch_unit_if bus();

    if_fetch_unit dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // PC register of the pipeline, loaded when the fetch unit strobes it
    always @(posedge Clk)
        bus.Pc <= Rst ? 32'd0 : pc_set ? pc_val : bus.Pc_Load ? bus.Next_Pc : bus.Pc;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL step %0d %s got %h expected %h", id, nm, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("req", e.id, {31'd0, bus.Imem_Req}, {31'd0, e.req});
            chk("addr", e.id, bus.Imem_Addr, e.addr);
            chk("pc_load", e.id, {31'd0, bus.Pc_Load}, {31'd0, e.ld});
            if (e.ld)
                chk("next_pc", e.id, bus.Next_Pc, e.npc);
            chk("valid", e.id, {31'd0, bus.IfId_Valid}, {31'd0, e.v});
            chk("instr", e.id, bus.IfId_Instr, e.ins);
            chk("pc4", e.id, bus.IfId_Pc4, e.pc4);
        end
    end

    task automatic step(input logic r, a, input logic [31:0] dt, input logic h, x, input logic [31:0] tg,
                        input logic e_req, input logic [31:0] e_addr, input logic e_ld, input logic [31:0] e_npc,
                        input logic e_v, input logic [31:0] e_ins, input logic [31:0] e_pc4);
        @(posedge Clk);
        #1;
        pc_set               = 1'b0;
        Rst                  = r;
        bus.Imem_Ack         = a;
        bus.Imem_Data        = dt;
        bus.Hold             = h;
        bus.Redirect         = x;
        bus.Redirect_Target  = tg;
        sid++;
        q.push_back('{sid, e_req, e_addr, e_ld, e_npc, e_v, e_ins, e_pc4});
    endtask

    initial begin
        checks = 0; errors = 0; sid = 0;
        Rst = 1'b1; pc_set = 1'b0; pc_val = 32'd0;
        bus.Imem_Ack = 1'b0; bus.Imem_Data = 32'd0; bus.Hold = 1'b0;
        bus.Redirect = 1'b0; bus.Redirect_Target = 32'd0;
        //   rst ack data  hold red tgt      req addr  ld npc   v ins  pc4
        step(1, 0, 0,      0, 0, 0,          0, 'h0,   0, 0,    0, 0,    0);
        step(0, 1, 'h11,   0, 0, 0,          1, 'h0,   1, 'h4,  0, 0,    0);
        step(0, 1, 'h22,   0, 0, 0,          1, 'h4,   1, 'h8,  1, 'h11, 'h4);
        step(0, 1, 'h33,   0, 0, 0,          1, 'h8,   1, 'hC,  1, 'h22, 'h8);
        step(1, 0, 0,      0, 0, 0,          0, 'hC,   0, 0,    1, 'h33, 'hC);
        step(0, 0, 0,      0, 0, 0,          1, 'h0,   0, 0,    0, 0,    0);
        step(0, 0, 0,      0, 0, 0,          1, 'h0,   0, 0,    0, 0,    0);
        step(0, 1, 'hAA,   0, 0, 0,          1, 'h0,   1, 'h4,  0, 0,    0);
        step(0, 1, 'h22,   1, 0, 0,          1, 'h4,   1, 'h8,  1, 'hAA, 'h4);
        step(0, 0, 0,      1, 0, 0,          0, 'h8,   0, 0,    1, 'hAA, 'h4);
        step(0, 0, 0,      1, 0, 0,          0, 'h8,   0, 0,    1, 'hAA, 'h4);
        step(0, 0, 0,      0, 0, 0,          0, 'h8,   0, 0,    1, 'hAA, 'h4);
        step(0, 1, 'h33,   0, 0, 0,          1, 'h8,   1, 'hC,  1, 'h22, 'h8);
        step(0, 1, 'h44,   0, 1, 'h100,      1, 'hC,   1, 'h100, 1, 'h33, 'hC);
        step(0, 1, 'h55,   0, 0, 0,          1, 'h100, 1, 'h104, 0, 0,   0);
        step(0, 0, 0,      1, 1, 'h200,      1, 'h104, 1, 'h200, 1, 'h55, 'h104);
        step(0, 0, 0,      0, 0, 0,          1, 'h104, 0, 0,    0, 0,    0);
        step(0, 1, 'hDEAD, 0, 0, 0,          1, 'h104, 0, 0,    0, 0,    0);
        step(0, 1, 'h66,   0, 0, 0,          1, 'h200, 1, 'h204, 0, 0,   0);
        step(0, 0, 0,      0, 0, 0,          1, 'h204, 0, 0,    1, 'h66, 'h204);
        pc_val = 32'hFFFF_FFFC;
        pc_set = 1'b1;
        step(0, 1, 'h77,   0, 0, 0,          1, 'hFFFF_FFFC, 1, 'h0, 0, 0, 0);
        step(0, 0, 0,      1, 0, 0,          1, 'h0,   0, 0,    1, 'h77, 'h0);
        step(0, 0, 0,      1, 0, 0,          1, 'h0,   0, 0,    1, 'h77, 'h0);
        step(1, 0, 0,      1, 0, 0,          0, 'h0,   0, 0,    1, 'h77, 'h0);
        step(0, 0, 0,      0, 0, 0,          1, 'h0,   0, 0,    0, 0,    0);
        step(0, 1, 'h88,   0, 0, 0,          1, 'h0,   1, 'h4,  0, 0,    0);
        step(0, 0, 0,      0, 0, 0,          1, 'h4,   0, 0,    1, 'h88, 'h4);
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge Clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
